// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch requester, the load/store requester, the arbiter and the unified memory.
// Latency: none, wires only.
// Backpressure: req/done handshakes per requester; mem_ready stalls the memory side.
//
// Port summary (directions as seen by the arbiter through the master modport):
//   fetch : if_req, if_addr in; if_done, if_rdata out
//   data  : d_req, d_we, d_addr, d_wdata, d_be in; d_done, d_rdata out
//   memory: mem_req, mem_we, mem_addr, mem_wdata, mem_be out; mem_ready, mem_rdata in
//   status: bus_err out (pulses with a done when an access timed out)
interface mem_port_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             if_req;
    logic [WIDTH-1:0] if_addr;
    logic             if_done;
    logic [WIDTH-1:0] if_rdata;

    logic             d_req;
    logic             d_we;
    logic [WIDTH-1:0] d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic [3:0]       d_be;
    logic             d_done;
    logic [WIDTH-1:0] d_rdata;

    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_rdata;

    logic             bus_err;

    // Arbiter side: serves both requesters and masters the memory port.
    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
        output if_done, if_rdata, d_done, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_err
    );

    // Environment side: requesters plus memory.
    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
        input  if_done, if_rdata, d_done, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store; data has priority, fetch is protected by a run limiter.
// Latency: grant 1 cycle after req, done 1 cycle after mem_ready (min req-to-done 2 cycles, max 1 access per 2 cycles).
// Backpressure: requesters hold req until done; mem_ready low holds the granted access on the port.
//
// Ports: clk, rst (async, active-high) plus bus (mem_port_arbiter_if.master):
//   fetch/data request+done+rdata, memory req/we/addr/wdata/be/ready/rdata, bus_err.
// Optional build macro ARB_TIMEOUT_EN: abandons an access after TIMEOUT_CYCLES access
//   cycles without mem_ready, pulsing the matching done with bus_err and zero read data.
module mem_port_arbiter #(
    parameter int WIDTH          = 32,
    parameter int MAX_RUN        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                 clk,
    input logic                 rst,
    mem_port_arbiter_if.master  bus
);
    localparam int RUN_W = $clog2(MAX_RUN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
    logic             if_done_q, if_done_d;
    logic             d_done_q, d_done_d;
    logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic             d_elig, f_elig, take_data, access_end;

    logic             mem_req, mem_we;
    logic [WIDTH-1:0] mem_addr, mem_wdata;
    logic [3:0]       mem_be;

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             access_err;
`endif

    // Memory port follows whoever owns the current access; all zero when idle.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'h0;
        case (state_q)
            DATA: begin
                mem_req   = 1'b1;
                mem_we    = bus.d_we;
                mem_addr  = bus.d_addr;
                mem_wdata = bus.d_wdata;
                mem_be    = bus.d_be;
            end
            FETCH: begin
                mem_req   = 1'b1;
                mem_addr  = bus.if_addr;
                mem_be    = 4'hF;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        access_end = 1'b0;
`ifdef ARB_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        bus_err_d  = 1'b0;
        access_err = 1'b0;
`endif
        // A requester whose done is showing still holds req this cycle;
        // it must not be granted again for the same request.
        d_elig    = bus.d_req & ~d_done_q;
        f_elig    = bus.if_req & ~if_done_q;
        take_data = d_elig & (~f_elig | (run_cnt_q < RUN_W'(MAX_RUN)));

        case (state_q)
            IDLE: begin
                if (take_data) begin
                    state_d = DATA;
                    // Count data grants that made a waiting fetch lose.
                    if (!f_elig)
                        run_cnt_d = '0;
                    else if (run_cnt_q != RUN_W'(MAX_RUN))
                        run_cnt_d = run_cnt_q + RUN_W'(1);
`ifdef ARB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end else if (f_elig) begin
                    state_d   = FETCH;
                    run_cnt_d = '0;
`ifdef ARB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            DATA, FETCH: begin
                access_end = bus.mem_ready;
`ifdef ARB_TIMEOUT_EN
                if (!bus.mem_ready) begin
                    if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        access_end = 1'b1;
                        access_err = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
`endif
                if (access_end) begin
                    state_d = IDLE;
                    if (state_q == DATA) begin
                        d_done_d = 1'b1;
                        if (!bus.d_we)
                            d_rdata_d = bus.mem_rdata;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
`ifdef ARB_TIMEOUT_EN
                    bus_err_d = access_err;
                    if (access_err) begin
                        if (state_q == DATA) begin
                            if (!bus.d_we)
                                d_rdata_d = '0;
                        end else begin
                            if_rdata_d = '0;
                        end
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            run_cnt_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q   <= '0;
            bus_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            bus_err_q  <= bus_err_d;
`endif
        end
    end

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_be    = mem_be;
    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.bus_err   = bus_err_q;
`else
    assign bus.bus_err   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cycle table, reset/timeout sequences, random traffic vs. a model.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled 2 units after it.
// Backpressure: random requesters hold req until done; random memory inserts wait states.
module tb_mem_port_arbiter;
    localparam int W       = 32;
    localparam int MAX_RUN = 4;
    localparam int TO      = 8;
    localparam logic [31:0] DA = 32'h0000_0100;
    localparam logic [31:0] WD = 32'hAABB_CCDD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WIDTH(W)) bus ();

    mem_port_arbiter #(.WIDTH(W), .MAX_RUN(MAX_RUN), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One table row = one clock cycle: inputs for the cycle and the outputs expected in it.
    typedef struct {
        bit          ireq;
        logic [31:0] iaddr;
        bit          dreq;
        bit          dwe;
        logic [3:0]  dbe;
        bit          rdy;
        logic [31:0] rdata;
        bit          e_req;
        bit          e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        bit          e_idone;
        bit          e_ddone;
        logic [31:0] e_ir;
        logic [31:0] e_dr;
    } vec_t;

    vec_t tbl [18];

    // Random-phase reference: who owns the port, plus the registered results.
    int          m_owner;   // 0 none, 1 data, 2 fetch
    int          m_run;
    int          m_wait;
    bit          m_idone, m_ddone, m_err;
    logic [31:0] m_ir, m_dr;

    bit          ireq, dreq, dwe;
    logic [31:0] iaddr, daddr, dwdata;
    logic [3:0]  dbe;

    task automatic drive_idle();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_be      = 4'h0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    initial begin
        bit got, seen_d;
        int acc;
        bit d_ok, f_ok, fin, err;

        //                 ireq iaddr       dreq dwe dbe    rdy rdata           e_req e_we e_be  e_addr      idone ddone e_ir            e_dr
        tbl[0]  = '{1, 32'h0,       0, 0, 4'h0, 0, 32'h0,         0, 0, 4'h0, 32'h0,  0, 0, 32'h0,         32'h0};
        tbl[1]  = '{1, 32'h0,       0, 0, 4'h0, 0, 32'h0,         1, 0, 4'hF, 32'h0,  0, 0, 32'h0,         32'h0};
        tbl[2]  = '{1, 32'h0,       0, 0, 4'h0, 1, 32'h00500093,  1, 0, 4'hF, 32'h0,  0, 0, 32'h0,         32'h0};
        tbl[3]  = '{1, 32'h0,       0, 0, 4'h0, 0, 32'h0,         0, 0, 4'h0, 32'h0,  1, 0, 32'h00500093,  32'h0};
        tbl[4]  = '{0, 32'h0,       0, 0, 4'h0, 0, 32'h0,         0, 0, 4'h0, 32'h0,  0, 0, 32'h00500093,  32'h0};
        tbl[5]  = '{1, 32'h4,       1, 0, 4'hF, 0, 32'h0,         0, 0, 4'h0, 32'h0,  0, 0, 32'h00500093,  32'h0};
        tbl[6]  = '{1, 32'h4,       1, 0, 4'hF, 1, 32'h12345678,  1, 0, 4'hF, DA,     0, 0, 32'h00500093,  32'h0};
        tbl[7]  = '{1, 32'h4,       1, 0, 4'hF, 0, 32'h0,         0, 0, 4'h0, 32'h0,  0, 1, 32'h00500093,  32'h12345678};
        tbl[8]  = '{1, 32'h4,       0, 0, 4'h0, 0, 32'h0,         1, 0, 4'hF, 32'h4,  0, 0, 32'h00500093,  32'h12345678};
        tbl[9]  = '{1, 32'h4,       0, 0, 4'h0, 1, 32'h11112222,  1, 0, 4'hF, 32'h4,  0, 0, 32'h00500093,  32'h12345678};
        tbl[10] = '{1, 32'h4,       0, 0, 4'h0, 0, 32'h0,         0, 0, 4'h0, 32'h0,  1, 0, 32'h11112222,  32'h12345678};
        tbl[11] = '{0, 32'h0,       1, 1, 4'h3, 0, 32'h0,         0, 0, 4'h0, 32'h0,  0, 0, 32'h11112222,  32'h12345678};
        tbl[12] = '{0, 32'h0,       1, 1, 4'h3, 0, 32'h0,         1, 1, 4'h3, DA,     0, 0, 32'h11112222,  32'h12345678};
        tbl[13] = '{0, 32'h0,       1, 1, 4'h3, 0, 32'h0,         1, 1, 4'h3, DA,     0, 0, 32'h11112222,  32'h12345678};
        tbl[14] = '{0, 32'h0,       1, 1, 4'h3, 0, 32'h0,         1, 1, 4'h3, DA,     0, 0, 32'h11112222,  32'h12345678};
        tbl[15] = '{0, 32'h0,       1, 1, 4'h3, 1, 32'hDEADBEEF,  1, 1, 4'h3, DA,     0, 0, 32'h11112222,  32'h12345678};
        tbl[16] = '{0, 32'h0,       1, 1, 4'h3, 0, 32'h0,         0, 0, 4'h0, 32'h0,  0, 1, 32'h11112222,  32'h12345678};
        tbl[17] = '{0, 32'h0,       0, 0, 4'h0, 0, 32'h0,         0, 0, 4'h0, 32'h0,  0, 0, 32'h11112222,  32'h12345678};

        // ---------------- reset state ----------------
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_mem_req",  32'(bus.mem_req),  32'h0);
        chk("reset_mem_addr", bus.mem_addr,      32'h0);
        chk("reset_mem_be",   32'(bus.mem_be),   32'h0);
        chk("reset_if_done",  32'(bus.if_done),  32'h0);
        chk("reset_d_done",   32'(bus.d_done),   32'h0);
        chk("reset_if_rdata", bus.if_rdata,      32'h0);
        chk("reset_d_rdata",  bus.d_rdata,       32'h0);
        chk("reset_bus_err",  32'(bus.bus_err),  32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---------------- directed table ----------------
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            bus.if_req    = tbl[i].ireq;
            bus.if_addr   = tbl[i].iaddr;
            bus.d_req     = tbl[i].dreq;
            bus.d_we      = tbl[i].dwe;
            bus.d_be      = tbl[i].dbe;
            bus.d_addr    = DA;
            bus.d_wdata   = WD;
            bus.mem_ready = tbl[i].rdy;
            bus.mem_rdata = tbl[i].rdata;
            #1;
            chk($sformatf("tbl%0d_mem_req", i),  32'(bus.mem_req),  32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_mem_we", i),   32'(bus.mem_we),   32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_mem_be", i),   32'(bus.mem_be),   32'(tbl[i].e_be));
            chk($sformatf("tbl%0d_mem_addr", i), bus.mem_addr,      tbl[i].e_addr);
            if (tbl[i].e_we)
                chk($sformatf("tbl%0d_mem_wdata", i), bus.mem_wdata, WD);
            chk($sformatf("tbl%0d_if_done", i),  32'(bus.if_done),  32'(tbl[i].e_idone));
            chk($sformatf("tbl%0d_d_done", i),   32'(bus.d_done),   32'(tbl[i].e_ddone));
            chk($sformatf("tbl%0d_if_rdata", i), bus.if_rdata,      tbl[i].e_ir);
            chk($sformatf("tbl%0d_d_rdata", i),  bus.d_rdata,       tbl[i].e_dr);
            chk($sformatf("tbl%0d_bus_err", i),  32'(bus.bus_err),  32'h0);
        end

        // ---------------- reset in the middle of a data access ----------------
        @(posedge clk); #1;
        drive_idle();
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h200;
        @(posedge clk); #1;
        chk("rst_pre_mem_req", 32'(bus.mem_req), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_mem_req", 32'(bus.mem_req), 32'h0);
        bus.d_req = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_hold_d_done",  32'(bus.d_done),  32'h0);
            chk("rst_hold_mem_req", 32'(bus.mem_req), 32'h0);
        end
        rst           = 1'b0;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h40;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0BADF00D;
        got    = 1'b0;
        seen_d = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.d_done)  seen_d = 1'b1;
            if (bus.if_done) got = 1'b1;
        end
        chk("rst_after_if_done",  32'(got),     32'h1);
        chk("rst_after_if_rdata", bus.if_rdata, 32'h0BADF00D);
        chk("rst_after_d_rdata",  bus.d_rdata,  32'h0);
        chk("rst_no_d_done",      32'(seen_d),  32'h0);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // ---------------- fetch timeout with memory never ready ----------------
        @(posedge clk); #1;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h80;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hFFFF_FFFF;
        acc = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.mem_req) acc++;
            if (bus.if_done) begin
                got = 1'b1;
                chk("to_bus_err",  32'(bus.bus_err), 32'h1);
                chk("to_if_rdata", bus.if_rdata,     32'h0);
            end
        end
        chk("to_if_done_seen",  32'(got), 32'h1);
        chk("to_access_cycles", 32'(acc), 32'(TO));
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        chk("to_idle_mem_req", 32'(bus.mem_req), 32'h0);
        chk("to_bus_err_clr",  32'(bus.bus_err), 32'h0);
`endif

        // ---------------- random traffic against the reference ----------------
        rst = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        m_owner = 0; m_run = 0; m_wait = 0;
        m_idone = 0; m_ddone = 0; m_err = 0;
        m_ir = '0; m_dr = '0;
        ireq = 0; dreq = 0; dwe = 0;
        iaddr = '0; daddr = '0; dwdata = '0; dbe = 4'h0;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            // Requesters: keep req until done has been seen, then drop or issue a new request.
            if (m_idone) begin
                if ($urandom_range(0, 1) == 0) ireq = 0;
                else iaddr = $urandom;
            end else if (!ireq && $urandom_range(0, 2) == 0) begin
                ireq = 1; iaddr = $urandom;
            end
            if (m_ddone) begin
                if ($urandom_range(0, 2) == 0) dreq = 0;
                else begin dwe = 1'($urandom_range(0, 1)); daddr = $urandom; dwdata = $urandom; dbe = 4'($urandom); end
            end else if (!dreq && $urandom_range(0, 1) == 0) begin
                dreq = 1; dwe = 1'($urandom_range(0, 1)); daddr = $urandom; dwdata = $urandom; dbe = 4'($urandom);
            end
            bus.if_req    = ireq;
            bus.if_addr   = iaddr;
            bus.d_req     = dreq;
            bus.d_we      = dwe;
            bus.d_addr    = daddr;
            bus.d_wdata   = dwdata;
            bus.d_be      = dbe;
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
            #1;

            chk("rnd_mem_req", 32'(bus.mem_req), 32'(m_owner != 0));
            if (m_owner == 1) begin
                chk("rnd_d_addr", bus.mem_addr,     daddr);
                chk("rnd_d_we",   32'(bus.mem_we),  32'(dwe));
                chk("rnd_d_be",   32'(bus.mem_be),  32'(dbe));
                if (dwe) chk("rnd_d_wdata", bus.mem_wdata, dwdata);
            end else if (m_owner == 2) begin
                chk("rnd_f_addr", bus.mem_addr,    iaddr);
                chk("rnd_f_we",   32'(bus.mem_we), 32'h0);
                chk("rnd_f_be",   32'(bus.mem_be), 32'hF);
            end
            chk("rnd_if_done",  32'(bus.if_done), 32'(m_idone));
            chk("rnd_d_done",   32'(bus.d_done),  32'(m_ddone));
            chk("rnd_if_rdata", bus.if_rdata,     m_ir);
            chk("rnd_d_rdata",  bus.d_rdata,      m_dr);
            chk("rnd_bus_err",  32'(bus.bus_err), 32'(m_err));

            // Advance the reference to the next cycle.
            d_ok = dreq && !m_ddone;
            f_ok = ireq && !m_idone;
            m_idone = 0; m_ddone = 0; m_err = 0;
            if (m_owner == 0) begin
                if (d_ok && (!f_ok || m_run < MAX_RUN)) begin
                    m_owner = 1;
                    m_run   = f_ok ? ((m_run + 1 > MAX_RUN) ? MAX_RUN : m_run + 1) : 0;
                    m_wait  = 0;
                end else if (f_ok) begin
                    m_owner = 2;
                    m_run   = 0;
                    m_wait  = 0;
                end
            end else begin
                fin = bus.mem_ready;
                err = 0;
`ifdef ARB_TIMEOUT_EN
                if (!fin) begin
                    m_wait++;
                    if (m_wait == TO) begin fin = 1; err = 1; end
                end
`endif
                if (fin) begin
                    m_err = err;
                    if (m_owner == 1) begin
                        m_ddone = 1;
                        if (!dwe) m_dr = err ? 32'h0 : bus.mem_rdata;
                    end else begin
                        m_idone = 1;
                        m_ir = err ? 32'h0 : bus.mem_rdata;
                    end
                    m_owner = 0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
